// File: rtl/givens_vec_gen_pkg.sv
// Shared constants for the Givens vectoring boundary cell.
package givens_vec_gen_pkg;

   localparam int DW = 13;
   localparam int N_GRP = 3;
   localparam logic signed [8:0] K_SCALE = 9'sd155;

   localparam logic [1:0] DIR_POS = 2'b01;
   localparam logic [1:0] DIR_NEG = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_G1   = 2'd1;
   localparam logic [1:0] ST_G2   = 2'd2;

endpackage

// File: rtl/givens_vec_gen_cordic_vec_grp.sv
// Four chained vectoring micro-rotations starting at shift 'base'.
module cordic_vec_grp
   import givens_vec_gen_pkg::*;
(
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] y,
   input  logic [3:0]    base,
   output logic [DW-1:0] x4,
   output logic [DW-1:0] y4,
   output logic [7:0]    d_sign
);

   logic signed [DW-1:0] xv, yv, xs, ys, xn, yn;
   logic [3:0]           sh;
   logic                 pos;

   always_comb begin
      xv     = $signed(x);
      yv     = $signed(y);
      xs     = '0;
      ys     = '0;
      xn     = '0;
      yn     = '0;
      sh     = '0;
      pos    = 1'b0;
      d_sign = '0;
      for (int j = 0; j < 4; j++) begin
         sh  = base + j[3:0];
         xs  = xv >>> sh;
         ys  = yv >>> sh;
         // y == 0 has a clear sign bit, so it is treated as positive
         pos = xv[DW-1] ^ yv[DW-1];
         if (pos) begin
            xn = xv - ys;
            yn = yv + xs;
         end else begin
            xn = xv + ys;
            yn = yv - xs;
         end
         xv = xn;
         yv = yn;
         d_sign[2*j +: 2] = pos ? DIR_POS : DIR_NEG;
      end
      x4 = xv;
      y4 = yv;
   end

endmodule

// File: rtl/givens_vec_gen.sv
// QR boundary cell: 12-step vectoring CORDIC, one group of 4 steps per cycle,
// emitting direction words for the row and the gain-compensated magnitude.
module givens_vec_gen
   import givens_vec_gen_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] x_in,
   input  logic [DW-1:0] y_in,
   output logic          in_ready,
   output logic [7:0]    d_sign_out,
   output logic          d_valid,
   output logic [1:0]    grp_idx,
   output logic          flip,
   output logic [DW-1:0] mag_out,
   output logic          mag_valid
);

   logic [1:0]           state;
   logic signed [DW-1:0] x_r, y_r;
   logic [DW-1:0]        gx, gy, x4, y4;
   logic [3:0]           gbase;
   logic [7:0]           gd;
   logic signed [21:0]   prod;

   assign in_ready = (state == ST_IDLE);

   // Single group datapath: fed from the pre-rotated inputs in IDLE, else from the regs.
   always_comb begin
      gx    = x_r;
      gy    = y_r;
      gbase = 4'd4;
      case (state)
         ST_IDLE: begin
            gbase = 4'd0;
            if (x_in[DW-1]) begin
               gx = -x_in;
               gy = -y_in;
            end else begin
               gx = x_in;
               gy = y_in;
            end
         end
         ST_G2:   gbase = 4'd8;
         default: gbase = 4'd4;
      endcase
   end

   cordic_vec_grp u_grp (
      .x      (gx),
      .y      (gy),
      .base   (gbase),
      .x4     (x4),
      .y4     (y4),
      .d_sign (gd)
   );

   assign prod = $signed({{9{x4[DW-1]}}, x4}) * $signed({{13{K_SCALE[8]}}, K_SCALE});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         x_r        <= '0;
         y_r        <= '0;
         d_sign_out <= '0;
         d_valid    <= 1'b0;
         grp_idx    <= '0;
         flip       <= 1'b0;
         mag_out    <= '0;
         mag_valid  <= 1'b0;
      end else begin
         mag_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  state      <= ST_G1;
                  x_r        <= x4;
                  y_r        <= y4;
                  d_sign_out <= gd;
                  grp_idx    <= 2'd0;
                  d_valid    <= 1'b1;
                  flip       <= x_in[DW-1];
               end else begin
                  d_valid <= 1'b0;
               end
            end
            ST_G1: begin
               state      <= ST_G2;
               x_r        <= x4;
               y_r        <= y4;
               d_sign_out <= gd;
               grp_idx    <= 2'd1;
            end
            ST_G2: begin
               state      <= ST_IDLE;
               x_r        <= x4;
               y_r        <= y4;
               d_sign_out <= gd;
               grp_idx    <= 2'd2;
               mag_out    <= prod[20:8];
               mag_valid  <= 1'b1;
            end
            default: begin
               state   <= ST_IDLE;
               d_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/givens_vec_gen.md
Name: givens_vec_gen

Overview:
- Boundary cell of the QR systolic array. Vectoring-mode CORDIC that drives an input pair (x, y) toward y = 0.
- Emits the per-micro-rotation direction words (d_sign) that the row's rotation cells consume. Each direction word is one signed 2-bit value per micro-rotation, packed four per 8-bit word.
- Outputs the K-scaled magnitude, which becomes the R diagonal element.
- Runs 12 micro-rotations as 3 groups of 4, one group per cycle, in lockstep with the rotation cells.

Parameters:
- K_SCALE, 9'd155, CORDIC gain compensation (155/256), signed 9-bit.
- N_GRP, 3, groups of 4 micro-rotations; fixed, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request to start a vectoring operation on x_in/y_in
- x_in  in  13  signed x operand
- y_in  in  13  signed y operand (element to annihilate)
- in_ready  out  1  block can accept; combinational, equals (state == IDLE)
- d_sign_out  out  8  direction word for the current group; [1:0]=iter 4g, [3:2]=4g+1, [5:4]=4g+2, [7:6]=4g+3
- d_valid  out  1  d_sign_out valid; drives rotation-cell en
- grp_idx  out  2  group index of d_sign_out (0,1,2)
- flip  out  1  operand was pre-negated (x_in < 0); held until next accept
- mag_out  out  13  signed scaled magnitude
- mag_valid  out  1  one-cycle pulse, mag_out valid

Behaviour:
- Reset (rst_n low, async) sets state IDLE, all outputs 0, internal x/y registers 0. Reset mid-operation aborts; no mag_valid is produced.
- States: IDLE, G1, G2.
  - IDLE: in_valid=1 accepts the operands, goes to G1.
  - G1 goes to G2 unconditionally.
  - G2 goes to IDLE unconditionally.
  - Throughput is one operation per 3 cycles; in_valid is ignored outside IDLE.
- Pre-rotation at accept: if x_in[12]=1, negate both x_in and y_in (13-bit two's complement wrap, so -4096 stays -4096) and set flip=1; otherwise flip=0.
- Micro-rotation i (i = 4g + j):
  - d = +1 if sign bits of x and y differ, else -1; y = 0 counts as positive.
  - x' = x - d*(y >>> i); y' = y + d*(x >>> i).
  - Arithmetic shift; 13-bit wraparound, no saturation, no overflow flag.
  - Encoding: +1 = 2'b01, -1 = 2'b11.
- Cycle timing, with the accept edge E0:
  - E0: group 0 computed combinationally from the pre-rotated inputs. d_sign_out<=group0, grp_idx<=0, d_valid<=1, x/y regs<=group result.
  - E1: group 1 from the regs; grp_idx<=1.
  - E2: group 2; grp_idx<=2. mag_out<=(x12*K_SCALE)[20:8] using a 22-bit signed product. mag_valid<=1.
  - E3: d_valid<=0 and mag_valid<=0, unless a new accept occurs at E3, in which case d_valid stays 1 and mag_valid drops.
  - d_valid is therefore high for exactly 3 consecutive cycles per operation, back-to-back capable.
- Operand range for a non-wrapping result is |x|,|y| ≤ 1023. Values outside that range wrap silently; this is defined behaviour.
- Final y is discarded and not output.
- Simultaneous rst_n deassertion and in_valid: the accept occurs on the first rising edge with rst_n high.

Decomposition:
- Shared package: K_SCALE, the 2-bit direction encodings (DIR_POS=2'b01, DIR_NEG=2'b11), data width 13, and the state enum.
- Sub-module cordic_vec_grp: combinational, 4 micro-rotations.
  - Inputs: x, y, base shift (0/4/8).
  - Outputs: x4, y4, 8-bit d_sign.
  - Instantiated once and muxed between the input path and the register path by state.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then released with in_valid=0 → all outputs 0, in_ready=1, no d_valid.
- Basic: x=300, y=400 at E0 → d_valid at E0..E2 with grp_idx 0,1,2. First d_sign nibble [1:0]=2'b11. mag_out within 500±3 at E2, mag_valid single pulse, flip=0.
- Negative x: x=-300, y=0 → flip=1, mag_out within 300±2, d_sign matches golden model bit-exactly.
- Axis case: x=100, y=0 → group0 d_sign[1:0]=2'b11, [3:2]=2'b01. mag_out within 100±2.
- Back-to-back with in_valid held high:
  - Accepts at E0 and E3; in_ready low during G1/G2.
  - d_valid continuous for 6 cycles; mag_valid at E2 and E5.
- Reset mid-op: rst_n low after E1 → outputs clear immediately (async), no mag_valid. Next accept after release behaves like the Basic case.
